range_display: RTL and testbench

- Downstream consumer of the ultrasonic distance stage.
- Accepts a binary distance in centimetres through a valid/ready handshake.
- Converts it to 4 BCD digits with a sequential double-dabble converter.
- Drives a 4-digit multiplexed 7-segment display with leading-zero blanking and an over-range indication.

---
 rtl/range_pkg.sv | 26 ++
 rtl/bin2bcd_seq.sv | 92 +++++++++
 rtl/range_display.sv | 91 +++++++++
 tb/tb_range_display.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared types and constants for the range display block.
package range_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LOAD
   } conv_state_t;

   localparam int unsigned MAX_DISPLAY = 9999;

   // Segment patterns {a,b,c,d,e,f,g}, active-high
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   // Non-decimal nibbles cannot come out of the converter; show them blank
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      if (nib <= 4'd9) return SEG_DIGIT[nib];
      return SEG_BLANK;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with valid/ready input handshake.
module bin2bcd_seq
   import range_pkg::*;
#(
   parameter int unsigned DIST_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIST_W-1:0] dist_cm,
   input  logic              dist_valid,
   output logic              dist_ready,
   output logic [15:0]       bcd,
   output logic              ovr,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(DIST_W + 1);
   localparam int unsigned CMP_W = (DIST_W > 14) ? DIST_W : 14;

   conv_state_t       state;
   conv_state_t       state_nxt;
   logic [DIST_W-1:0] bin_sr;
   logic [15:0]       bcd_sr;
   logic [15:0]       bcd_adj;
   logic [CNT_W-1:0]  cnt;
   logic              ovr_r;
   logic              accept;

   assign accept = dist_valid && dist_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: one shift per input bit, then a single load cycle
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
         ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and completion outputs
   always_comb begin
      dist_ready = (state == ST_IDLE) && !rst;
      done       = (state == ST_LOAD);
   end

   // Add-3 correction on every BCD nibble that is 5 or more
   always_comb begin
      bcd_adj = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
         else                          bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4];
      end
   end

   // Conversion datapath: capture on accept, correct-and-shift while busy
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_sr <= '0;
         bcd_sr <= '0;
         cnt    <= '0;
         ovr_r  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  bin_sr <= dist_cm;
                  bcd_sr <= '0;
                  cnt    <= CNT_W'(DIST_W);
                  ovr_r  <= (CMP_W'(dist_cm) > CMP_W'(MAX_DISPLAY));
               end
            end
            ST_SHIFT: begin
               {bcd_sr, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
               cnt              <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bcd = bcd_sr;
   assign ovr = ovr_r;

endmodule

// File: rtl/range_display.sv
// Distance readout: BCD conversion feeding a 4-digit multiplexed 7-segment display.
module range_display
   import range_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 27000000,
   parameter int unsigned SCAN_HZ    = 1000,
   parameter int unsigned DIST_W     = 14,
   parameter int unsigned LEAD_BLANK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIST_W-1:0] dist_cm,
   input  logic              dist_valid,
   output logic              dist_ready,
   output logic [6:0]        seg_out,
   output logic [3:0]        digit_en,
   output logic [15:0]       bcd_out
);

   localparam int unsigned SCAN_RAW = CLK_HZ / (SCAN_HZ * 4);
   localparam int unsigned SCAN_DIV = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
   localparam int unsigned PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [15:0]      conv_bcd;
   logic             conv_ovr;
   logic             conv_done;
   logic             ovr_disp;
   logic [PRE_W-1:0] presc;
   logic [1:0]       scan_idx;
   logic [6:0]       seg_nxt;
   logic [15:0]      upper;

   bin2bcd_seq #(
      .DIST_W(DIST_W)
   ) u_conv (
      .clk        (clk),
      .rst        (rst),
      .dist_cm    (dist_cm),
      .dist_valid (dist_valid),
      .dist_ready (dist_ready),
      .bcd        (conv_bcd),
      .ovr        (conv_ovr),
      .done       (conv_done)
   );

   // Displayed value and over-range flag update together on conversion done
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_out  <= '0;
         ovr_disp <= 1'b0;
      end else if (conv_done) begin
         bcd_out  <= conv_bcd;
         ovr_disp <= conv_ovr;
      end
   end

   // Prescaler and digit scan index
   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         scan_idx <= '0;
      end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
         presc    <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         presc    <= presc + PRE_W'(1);
      end
   end

   // Segment pattern for the digit currently selected by the scan index
   always_comb begin
      upper   = bcd_out >> {scan_idx, 2'b00};
      seg_nxt = seg_decode(bcd_out[{scan_idx, 2'b00} +: 4]);
      if (ovr_disp)
         seg_nxt = SEG_DASH;
      else if ((LEAD_BLANK != 0) && (scan_idx != 2'd0) && (upper == '0))
         seg_nxt = SEG_BLANK;
   end

   // Registered display drive, one cycle behind the scan index
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_out  <= '0;
         digit_en <= 4'b0001;
      end else begin
         seg_out  <= seg_nxt;
         digit_en <= 4'b0001 << scan_idx;
      end
   end

endmodule

// File: tb/tb_range_display.sv
// Directed testbench for range_display: two instances, leading-zero blanking on and off.
module tb_range_display;

   localparam logic [6:0] S0 = 7'b1111110;
   localparam logic [6:0] S1 = 7'b0110000;
   localparam logic [6:0] S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001;
   localparam logic [6:0] S4 = 7'b0110011;
   localparam logic [6:0] S5 = 7'b1011011;
   localparam logic [6:0] S7 = 7'b1110000;
   localparam logic [6:0] S8 = 7'b1111111;
   localparam logic [6:0] S9 = 7'b1111011;
   localparam logic [6:0] SB = 7'b0000000;
   localparam logic [6:0] SD = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] dist_cm;
   logic        dist_valid;
   logic        ready_a, ready_b;
   logic [6:0]  seg_a, seg_b;
   logic [3:0]  de_a, de_b;
   logic [15:0] bcd_a, bcd_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   range_display #(
      .CLK_HZ(4000), .SCAN_HZ(100), .DIST_W(14), .LEAD_BLANK(1)
   ) dut_a (
      .clk(clk), .rst(rst), .dist_cm(dist_cm), .dist_valid(dist_valid),
      .dist_ready(ready_a), .seg_out(seg_a), .digit_en(de_a), .bcd_out(bcd_a)
   );

   range_display #(
      .CLK_HZ(4000), .SCAN_HZ(100), .DIST_W(14), .LEAD_BLANK(0)
   ) dut_b (
      .clk(clk), .rst(rst), .dist_cm(dist_cm), .dist_valid(dist_valid),
      .dist_ready(ready_b), .seg_out(seg_b), .digit_en(de_b), .bcd_out(bcd_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one value for a single cycle (converter idle) and wait for the load
   task automatic convert(input logic [13:0] value);
      dist_cm    = value;
      dist_valid = 1'b1;
      tick;
      dist_valid = 1'b0;
      repeat (15) tick;
   endtask

   // Observe one full 40-cycle scan; segs holds digit i at [7*i +: 7],
   // good[i] clears if that digit was not held steady for exactly 10 cycles
   task automatic capture_scan(input bit sel, output logic [27:0] segs, output logic [3:0] good);
      int         cnt [4];
      int         idx;
      logic [6:0] s;
      logic [3:0] de;
      segs = '0;
      good = 4'hF;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int c = 0; c < 40; c++) begin
         tick;
         s  = sel ? seg_b : seg_a;
         de = sel ? de_b : de_a;
         case (de)
            4'b0001: idx = 0;
            4'b0010: idx = 1;
            4'b0100: idx = 2;
            4'b1000: idx = 3;
            default: idx = -1;
         endcase
         if (idx < 0) good = 4'h0;
         else begin
            if (cnt[idx] == 0) segs[7*idx +: 7] = s;
            else if (segs[7*idx +: 7] !== s) good[idx] = 1'b0;
            cnt[idx]++;
         end
      end
      for (int i = 0; i < 4; i++) if (cnt[i] != 10) good[i] = 1'b0;
   endtask

   task automatic test_reset;
      logic [27:0] segs;
      logic [3:0]  good;
      rst = 1'b1; dist_valid = 1'b0; dist_cm = '0;
      repeat (3) tick;
      tests++;
      if (seg_a !== 7'b0000000 || de_a !== 4'b0001 || ready_a !== 1'b0 || bcd_a !== 16'h0000) begin
         fails++;
         $display("FAIL reset_hold: seg=%b en=%b rdy=%b bcd=%h, want 0000000 0001 0 0000", seg_a, de_a, ready_a, bcd_a);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (ready_a !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: rdy=%b want 1", ready_a);
      end
      tick;
      tests++;
      if (seg_a !== S0 || de_a !== 4'b0001) begin
         fails++;
         $display("FAIL reset_first_digit: seg=%b en=%b want %b 0001", seg_a, de_a, S0);
      end
      capture_scan(1'b0, segs, good);
      tests++;
      if (segs !== {SB, SB, SB, S0} || good !== 4'hF) begin
         fails++;
         $display("FAIL reset_scan: segs=%h good=%b want %h 1111", segs, good, {SB, SB, SB, S0});
      end
   endtask

   task automatic test_1234;
      logic [27:0] segs;
      logic [3:0]  good;
      dist_cm = 14'd1234; dist_valid = 1'b1;
      tick;
      dist_valid = 1'b0;
      tests++;
      if (ready_a !== 1'b0) begin
         fails++;
         $display("FAIL busy_ready: rdy=%b want 0", ready_a);
      end
      repeat (14) tick;
      tests++;
      if (bcd_a !== 16'h0000 || ready_a !== 1'b0) begin
         fails++;
         $display("FAIL latency_early: bcd=%h rdy=%b want 0000 0", bcd_a, ready_a);
      end
      tick;
      tests++;
      if (bcd_a !== 16'h1234 || ready_a !== 1'b1) begin
         fails++;
         $display("FAIL latency_1234: bcd=%h rdy=%b want 1234 1", bcd_a, ready_a);
      end
      capture_scan(1'b0, segs, good);
      tests++;
      if (segs !== {S1, S2, S3, S4} || good !== 4'hF) begin
         fails++;
         $display("FAIL scan_1234: segs=%h good=%b want %h 1111", segs, good, {S1, S2, S3, S4});
      end
   endtask

   task automatic test_lead_blank;
      logic [27:0] segs;
      logic [3:0]  good;
      convert(14'd7);
      tests++;
      if (bcd_a !== 16'h0007 || bcd_b !== 16'h0007) begin
         fails++;
         $display("FAIL bcd_7: a=%h b=%h want 0007", bcd_a, bcd_b);
      end
      capture_scan(1'b0, segs, good);
      tests++;
      if (segs !== {SB, SB, SB, S7} || good !== 4'hF) begin
         fails++;
         $display("FAIL blank_on_7: segs=%h good=%b want %h 1111", segs, good, {SB, SB, SB, S7});
      end
      capture_scan(1'b1, segs, good);
      tests++;
      if (segs !== {S0, S0, S0, S7} || good !== 4'hF) begin
         fails++;
         $display("FAIL blank_off_7: segs=%h good=%b want %h 1111", segs, good, {S0, S0, S0, S7});
      end
   endtask

   task automatic test_over_range;
      logic [27:0] segs;
      logic [3:0]  good;
      convert(14'd10000);
      tests++;
      if (bcd_a !== 16'h0000) begin
         fails++;
         $display("FAIL bcd_10000: bcd=%h want 0000", bcd_a);
      end
      capture_scan(1'b0, segs, good);
      tests++;
      if (segs !== {SD, SD, SD, SD} || good !== 4'hF) begin
         fails++;
         $display("FAIL dash_10000: segs=%h good=%b want %h 1111", segs, good, {SD, SD, SD, SD});
      end
      convert(14'd9999);
      tests++;
      if (bcd_a !== 16'h9999) begin
         fails++;
         $display("FAIL bcd_9999: bcd=%h want 9999", bcd_a);
      end
      capture_scan(1'b0, segs, good);
      tests++;
      if (segs !== {S9, S9, S9, S9} || good !== 4'hF) begin
         fails++;
         $display("FAIL scan_9999: segs=%h good=%b want %h 1111", segs, good, {S9, S9, S9, S9});
      end
   endtask

   task automatic test_back_to_back;
      dist_cm = 14'd42; dist_valid = 1'b1;
      tick;
      dist_cm = 14'd56;
      tests++;
      if (ready_a !== 1'b0) begin
         fails++;
         $display("FAIL b2b_busy: rdy=%b want 0", ready_a);
      end
      repeat (14) tick;
      tests++;
      if (bcd_a !== 16'h9999 || ready_a !== 1'b0) begin
         fails++;
         $display("FAIL b2b_hold: bcd=%h rdy=%b want 9999 0", bcd_a, ready_a);
      end
      tick;
      tests++;
      if (bcd_a !== 16'h0042 || ready_a !== 1'b1) begin
         fails++;
         $display("FAIL b2b_42: bcd=%h rdy=%b want 0042 1", bcd_a, ready_a);
      end
      tick;
      dist_valid = 1'b0;
      tests++;
      if (bcd_a !== 16'h0042 || ready_a !== 1'b0) begin
         fails++;
         $display("FAIL b2b_accept56: bcd=%h rdy=%b want 0042 0", bcd_a, ready_a);
      end
      repeat (14) tick;
      tests++;
      if (bcd_a !== 16'h0042) begin
         fails++;
         $display("FAIL b2b_56_early: bcd=%h want 0042", bcd_a);
      end
      tick;
      tests++;
      if (bcd_a !== 16'h0056 || ready_a !== 1'b1) begin
         fails++;
         $display("FAIL b2b_56: bcd=%h rdy=%b want 0056 1", bcd_a, ready_a);
      end
      repeat (20) tick;
      tests++;
      if (bcd_a !== 16'h0056 || ready_a !== 1'b1) begin
         fails++;
         $display("FAIL b2b_settle: bcd=%h rdy=%b want 0056 1", bcd_a, ready_a);
      end
   endtask

   task automatic test_reset_mid;
      logic [27:0] segs;
      logic [3:0]  good;
      dist_cm = 14'd850; dist_valid = 1'b1;
      tick;
      dist_valid = 1'b0;
      repeat (4) tick;
      rst = 1'b1;
      repeat (2) tick;
      tests++;
      if (bcd_a !== 16'h0000 || ready_a !== 1'b0 || seg_a !== 7'b0000000 || de_a !== 4'b0001) begin
         fails++;
         $display("FAIL midrst_hold: bcd=%h rdy=%b seg=%b en=%b want 0000 0 0000000 0001", bcd_a, ready_a, seg_a, de_a);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (ready_a !== 1'b1) begin
         fails++;
         $display("FAIL midrst_ready: rdy=%b want 1", ready_a);
      end
      capture_scan(1'b0, segs, good);
      tests++;
      if (segs !== {SB, SB, SB, S0} || good !== 4'hF) begin
         fails++;
         $display("FAIL midrst_scan: segs=%h good=%b want %h 1111", segs, good, {SB, SB, SB, S0});
      end
      convert(14'd850);
      tests++;
      if (bcd_a !== 16'h0850) begin
         fails++;
         $display("FAIL midrst_850: bcd=%h want 0850", bcd_a);
      end
      capture_scan(1'b0, segs, good);
      tests++;
      if (segs !== {SB, S8, S5, S0} || good !== 4'hF) begin
         fails++;
         $display("FAIL scan_850: segs=%h good=%b want %h 1111", segs, good, {SB, S8, S5, S0});
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; dist_valid = 1'b0; dist_cm = '0;
      test_reset;
      test_1234;
      test_lead_blank;
      test_over_range;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
